// File: rtl/ipb_io_regbank.sv
// IPbus register bank: R0..R7 read/write, status snapshot at 8, fixed-latency read handshake.
// Optional write counter at address 15 is built when IO_WR_COUNT_EN is defined.
module ipb_io_regbank #(
    parameter int RD_LATENCY = 3
) (
    input  logic        clk,
    input  logic        res,
    input  logic        io_sync,
    input  logic        io_rd_en,
    input  logic        io_wr_en,
    input  logic [3:0]  ipb_addr,
    input  logic [31:0] ipb_wdata,
    input  logic [31:0] status_in,
    output logic        io_rd_ack,
    output logic [31:0] io_rdata,
    output logic [31:0] ctrl_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(RD_LATENCY - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_rd_en_prev;
    logic        r_ack;
    logic [31:0] r_rdata;
    logic [31:0] r_snap;
    logic [31:0] r_regs [0:7];
    logic [31:0] w_sel;
    logic        w_rd_start;
    logic        w_abort;
    logic        w_ack_nxt;

`ifdef IO_WR_COUNT_EN
    logic [31:0] r_wr_cnt;

    // Free-running count of write strobes, wraps naturally at 32 bits.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_wr_cnt <= 32'd0;
        end else if (io_wr_en) begin
            r_wr_cnt <= r_wr_cnt + 32'd1;
        end else begin
            r_wr_cnt <= r_wr_cnt;
        end
    end
`endif

    // Register file write port; addresses 8..15 are not writable.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (io_wr_en && (ipb_addr[3] == 1'b0)) begin
            r_regs[ipb_addr[2:0]] <= ipb_wdata;
        end else begin
            r_regs <= r_regs;
        end
    end

    // Read-data mux evaluated in the read-start cycle.
    always_comb begin
        w_sel = 32'd0;
        case (ipb_addr)
            4'd8:    w_sel = status_in;
`ifdef IO_WR_COUNT_EN
            4'd15:   w_sel = r_wr_cnt;
`endif
            default: w_sel = (ipb_addr[3] == 1'b0) ? r_regs[ipb_addr[2:0]] : 32'd0;
        endcase
    end

    assign w_rd_start = io_rd_en & ~r_rd_en_prev & io_sync;
    assign w_abort    = ~io_sync | ~io_rd_en;

    // Next-state logic; ack is looked ahead so it can be registered.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_rd_start) begin
                    w_state_nxt = RD_WAIT;
                    w_cnt_nxt   = LAT_M1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RD_WAIT: begin
                if (w_abort) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = RD_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            RD_DONE: begin
                if (!io_rd_en) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RD_DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
        w_ack_nxt = (w_state_nxt == RD_WAIT) && (w_cnt_nxt == 4'd0);
    end

    // Read FSM and registered outputs; rd_en history resets high so a held
    // io_rd_en across reset release is not mistaken for a new read.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_rd_en_prev <= 1'b1;
            r_ack        <= 1'b0;
            r_rdata      <= 32'd0;
            r_snap       <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_rd_en_prev <= io_rd_en;
            r_ack        <= w_ack_nxt;
            if ((r_state == IDLE) && w_rd_start) begin
                r_snap <= w_sel;
            end else begin
                r_snap <= r_snap;
            end
            if (w_ack_nxt) begin
                r_rdata <= (r_state == IDLE) ? w_sel : r_snap;
            end else begin
                r_rdata <= r_rdata;
            end
        end
    end

    assign io_rd_ack = r_ack;
    assign io_rdata  = r_rdata;
    assign ctrl_out  = r_regs[0];

endmodule

// File: tb/tb_ipb_io_regbank.sv
// Directed self-checking bench for ipb_io_regbank (RD_LATENCY = 3).
module tb_ipb_io_regbank;

    logic        clk;
    logic        res;
    logic        io_sync;
    logic        io_rd_en;
    logic        io_wr_en;
    logic [3:0]  ipb_addr;
    logic [31:0] ipb_wdata;
    logic [31:0] status_in;
    logic        io_rd_ack;
    logic [31:0] io_rdata;
    logic [31:0] ctrl_out;

    int checks = 0;
    int errors = 0;

    ipb_io_regbank #(.RD_LATENCY(3)) dut (
        .clk       (clk),
        .res       (res),
        .io_sync   (io_sync),
        .io_rd_en  (io_rd_en),
        .io_wr_en  (io_wr_en),
        .ipb_addr  (ipb_addr),
        .ipb_wdata (ipb_wdata),
        .status_in (status_in),
        .io_rd_ack (io_rd_ack),
        .io_rdata  (io_rdata),
        .ctrl_out  (ctrl_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        io_wr_en  = 1'b1;
        ipb_addr  = a;
        ipb_wdata = d;
        cyc();
        io_wr_en  = 1'b0;
    endtask

    // Hold io_rd_en for 'hold' cycles after the start cycle, then release.
    task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input int hold,
                           input bit clr_status, input bit wr_same, input logic [31:0] wd,
                           input string tag);
        int          acks;
        int          first;
        logic [31:0] got;
        acks  = 0;
        first = -1;
        got   = 32'hXXXX_XXXX;
        ipb_addr = a;
        io_sync  = 1'b1;
        io_rd_en = 1'b1;
        if (wr_same) begin
            io_wr_en  = 1'b1;
            ipb_wdata = wd;
        end
        for (int c = 1; c <= hold; c++) begin
            cyc();
            io_wr_en = 1'b0;
            if (clr_status) status_in = 32'd0;
            if (io_rd_ack === 1'b1) begin
                acks++;
                if (first < 0) begin
                    first = c;
                    got   = io_rdata;
                end
            end
        end
        check({tag, "_ack_cycle"}, 32'(first), 32'd3);
        check({tag, "_ack_count"}, 32'(acks), 32'd1);
        check({tag, "_data"}, got, exp);
        check({tag, "_data_held"}, io_rdata, exp);
        io_rd_en = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        int acks;
        res       = 1'b1;
        io_sync   = 1'b0;
        io_rd_en  = 1'b0;
        io_wr_en  = 1'b0;
        ipb_addr  = 4'd0;
        ipb_wdata = 32'd0;
        status_in = 32'd0;
        #3;
        check("rst_ack", {31'd0, io_rd_ack}, 32'd0);
        check("rst_rdata", io_rdata, 32'd0);
        check("rst_ctrl", ctrl_out, 32'd0);
        cyc();
        cyc();
        res = 1'b0;
        cyc();

        // Basic write then read
        wr(4'd3, 32'hDEAD_BEEF);
        do_read(4'd3, 32'hDEAD_BEEF, 5, 1'b0, 1'b0, 32'd0, "rd_r3");

        // Status snapshot taken at read start
        status_in = 32'h1234_5678;
        do_read(4'd8, 32'h1234_5678, 5, 1'b1, 1'b0, 32'd0, "rd_status");

        // Held io_rd_en: one ack only
        wr(4'd6, 32'hA5A5_0F0F);
        do_read(4'd6, 32'hA5A5_0F0F, 10, 1'b0, 1'b0, 32'd0, "rd_held");

        // io_sync dropped in RD_WAIT aborts the read
        ipb_addr = 4'd3;
        io_sync  = 1'b1;
        io_rd_en = 1'b1;
        cyc();
        io_sync = 1'b0;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (io_rd_ack === 1'b1) acks++;
        end
        check("abort_no_ack", 32'(acks), 32'd0);
        check("abort_rdata_kept", io_rdata, 32'hA5A5_0F0F);
        io_rd_en = 1'b0;
        cyc();
        do_read(4'd3, 32'hDEAD_BEEF, 5, 1'b0, 1'b0, 32'd0, "rd_after_abort");

        // Writes to 9 are ignored; ctrl_out follows R0
        wr(4'd9, 32'hFFFF_FFFF);
        do_read(4'd9, 32'd0, 5, 1'b0, 1'b0, 32'd0, "rd_addr9");
        wr(4'd0, 32'h0000_00C3);
        check("ctrl_w1", ctrl_out, 32'h0000_00C3);
        wr(4'd0, 32'h8001_0002);
        check("ctrl_w2", ctrl_out, 32'h8001_0002);
        do_read(4'd0, 32'h8001_0002, 5, 1'b0, 1'b0, 32'd0, "rd_r0");

        // Coincident write returns the pre-write value, new value later
        wr(4'd5, 32'h1111_1111);
        do_read(4'd5, 32'h1111_1111, 5, 1'b0, 1'b1, 32'h2222_2222, "rd_coinc");
        do_read(4'd5, 32'h2222_2222, 5, 1'b0, 1'b0, 32'd0, "rd_coinc_new");
        do_read(4'd7, 32'd0, 4, 1'b0, 1'b0, 32'd0, "rd_r7_zero");

`ifdef IO_WR_COUNT_EN
        dut.r_wr_cnt = 32'hFFFF_FFFE;
        wr(4'd10, 32'd1);
        wr(4'd11, 32'd2);
        wr(4'd12, 32'd3);
        do_read(4'd15, 32'd1, 5, 1'b0, 1'b0, 32'd0, "rd_wrcnt_wrap");
`else
        wr(4'd15, 32'h5555_AAAA);
        do_read(4'd15, 32'd0, 5, 1'b0, 1'b0, 32'd0, "rd_addr15");
`endif

        // Reset during the ack cycle drops the ack at once
        ipb_addr = 4'd3;
        io_sync  = 1'b1;
        io_rd_en = 1'b1;
        cyc();
        cyc();
        cyc();
        check("mid_ack_before_rst", {31'd0, io_rd_ack}, 32'd1);
        #2;
        res = 1'b1;
        #1;
        check("mid_rst_ack", {31'd0, io_rd_ack}, 32'd0);
        check("mid_rst_rdata", io_rdata, 32'd0);
        check("mid_rst_ctrl", ctrl_out, 32'd0);
        cyc();
        res = 1'b0;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (io_rd_ack === 1'b1) acks++;
        end
        check("post_rst_no_restart", 32'(acks), 32'd0);
        io_rd_en = 1'b0;
        cyc();
        do_read(4'd3, 32'd0, 5, 1'b0, 1'b0, 32'd0, "rd_r3_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
